// File: rtl/ita_input_row_assembler_pkg.sv
// Shared sizing, types and FSM states for the ITA input row assembler.
// Beats of N bytes are packed into rows of E bytes for the input memory.
package ita_input_row_assembler_pkg;

   localparam int N  = 16;
   localparam int E  = 64;
   localparam int S  = 64;
   localparam int WI = 8;

   function automatic int idx_width(input int num);
      return (num > 1) ? $clog2(num) : 1;
   endfunction

   localparam int BeatsPerRow    = E / N;
   localparam int InputAddrWidth = idx_width(S);

   typedef logic [idx_width(E/N)-1:0] beat_cnt_t;
   typedef logic [idx_width(S+1)-1:0] row_cnt_t;
   typedef logic [idx_width(S+1)-1:0] seq_length_t;
   typedef logic [idx_width(E+1)-1:0] embed_size_t;
   typedef logic [N*WI-1:0]           fifo_data_t;

   typedef struct packed {
      logic [InputAddrWidth-1:0] addr;
      logic [E*WI-1:0]           data;
   } write_port_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

endpackage

// File: rtl/ita_row_output_reg.sv
// Single-entry valid/ready holding register for assembled rows.
// A pop and a push in the same cycle replace the entry without a bubble.
module ita_row_output_reg
   import ita_input_row_assembler_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  write_port_t push_data_i,
   input  logic        ready_i,
   output logic        valid_o,
   output write_port_t data_o
);

   logic        valid_reg, valid_next;
   write_port_t data_reg, data_next;

   always_comb begin
      valid_next = valid_reg;
      data_next  = data_reg;
      if (valid_reg && ready_i) begin
         valid_next = 1'b0;
      end
      if (push_i) begin
         valid_next = 1'b1;
         data_next  = push_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else begin
         valid_reg <= valid_next;
         data_reg  <= data_next;
      end
   end

   assign valid_o = valid_reg;
   assign data_o  = data_reg;

endmodule

// File: rtl/ita_input_row_assembler.sv
// Packs N-byte input beats into E-byte rows and writes rows 0..seq_length-1
// of one tile into the input memory, pulsing done_o after the last write.
module ita_input_row_assembler
   import ita_input_row_assembler_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  seq_length_t seq_length_i,
   input  embed_size_t embed_size_i,
   input  logic        inp_valid_i,
   output logic        inp_ready_o,
   input  fifo_data_t  inp_data_i,
   output logic        wr_valid_o,
   input  logic        wr_ready_i,
   output write_port_t wr_port_o,
   output logic        busy_o,
   output logic        done_o
);

   state_t          state_reg, state_next;
   beat_cnt_t       beat_cnt_reg, beat_cnt_next;
   beat_cnt_t       last_beat_reg, last_beat_next;
   row_cnt_t        row_cnt_reg, row_cnt_next;
   seq_length_t     seq_length_reg, seq_length_next;
   logic            done_reg, done_next;
   logic [E*WI-1:0] row_reg;
   logic [E*WI-1:0] assembled;
   embed_size_t     beats_cfg;

   logic        last_beat, last_row, inp_ready, accept, push, out_valid;
   write_port_t push_port, out_port;

   assign last_beat = (beat_cnt_reg == last_beat_reg);
   assign last_row  = (row_cnt_reg == (seq_length_reg - seq_length_t'(1)));
   // Only the last beat of a row waits for room in the output register.
   assign inp_ready = (state_reg == RUN) && (!last_beat || !out_valid || wr_ready_i);
   assign accept    = inp_valid_i && inp_ready;
   assign push      = accept && last_beat;

   // The incoming beat is merged combinationally so the final beat of a row
   // goes straight to the output register; slices past embed_size read as 0.
   genvar gi;
   generate
      for (gi = 0; gi < BeatsPerRow; gi++) begin : g_beat
         assign assembled[gi*N*WI +: N*WI] =
            (beat_cnt_t'(gi) > last_beat_reg)  ? '0 :
            (beat_cnt_t'(gi) == beat_cnt_reg) ? inp_data_i :
                                                row_reg[gi*N*WI +: N*WI];
      end
   endgenerate

   assign push_port.addr = row_cnt_reg[InputAddrWidth-1:0];
   assign push_port.data = assembled;

   ita_row_output_reg u_out_reg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_data_i (push_port),
      .ready_i     (wr_ready_i),
      .valid_o     (out_valid),
      .data_o      (out_port)
   );

   always_comb begin
      state_next      = state_reg;
      beat_cnt_next   = beat_cnt_reg;
      last_beat_next  = last_beat_reg;
      row_cnt_next    = row_cnt_reg;
      seq_length_next = seq_length_reg;
      done_next       = 1'b0;
      beats_cfg       = embed_size_i / embed_size_t'(N);
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               seq_length_next = seq_length_i;
               last_beat_next  = beat_cnt_t'(beats_cfg - embed_size_t'(1));
               beat_cnt_next   = '0;
               row_cnt_next    = '0;
               if (seq_length_i == '0) begin
                  done_next = 1'b1;
               end else begin
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (accept) begin
               if (last_beat) begin
                  beat_cnt_next = '0;
                  row_cnt_next  = row_cnt_reg + row_cnt_t'(1);
                  if (last_row) begin
                     state_next = DRAIN;
                  end
               end else begin
                  beat_cnt_next = beat_cnt_reg + beat_cnt_t'(1);
               end
            end
         end
         DRAIN: begin
            if (out_valid && wr_ready_i) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= IDLE;
         beat_cnt_reg   <= '0;
         last_beat_reg  <= '0;
         row_cnt_reg    <= '0;
         seq_length_reg <= '0;
         done_reg       <= 1'b0;
         row_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         beat_cnt_reg   <= beat_cnt_next;
         last_beat_reg  <= last_beat_next;
         row_cnt_reg    <= row_cnt_next;
         seq_length_reg <= seq_length_next;
         done_reg       <= done_next;
         if (accept && !last_beat) begin
            row_reg <= assembled;
         end
      end
   end

   assign inp_ready_o = inp_ready;
   assign wr_valid_o  = out_valid;
   assign wr_port_o   = out_port;
   assign busy_o      = (state_reg != IDLE);
   assign done_o      = done_reg;

endmodule

// File: tb/tb_ita_input_row_assembler.sv
// Scoreboard bench: rows are queued as their last beat is issued and a
// negedge monitor pops and compares on every write handshake.
module tb_ita_input_row_assembler;
   import ita_input_row_assembler_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, inp_valid_i, wr_ready_i;
   logic        inp_ready_o, wr_valid_o, busy_o, done_o;
   seq_length_t seq_length_i;
   embed_size_t embed_size_i;
   fifo_data_t  inp_data_i;
   write_port_t wr_port_o;

   typedef struct packed {
      write_port_t wp;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_at = -1;
   int          done_cnt = 0;
   int          ready_mode = 0;
   bit          tput_check = 0;
   bit          first_hs = 1;
   int          last_hs = 0;
   bit          prev_stall = 0;
   write_port_t prev_port;

   ita_input_row_assembler dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .seq_length_i (seq_length_i),
      .embed_size_i (embed_size_i),
      .inp_valid_i  (inp_valid_i),
      .inp_ready_o  (inp_ready_o),
      .inp_data_i   (inp_data_i),
      .wr_valid_o   (wr_valid_o),
      .wr_ready_i   (wr_ready_i),
      .wr_port_o    (wr_port_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // Output-side ready: 0 = tied high, 1 = random, 2 = driven by the main sequence.
   initial forever begin
      @(posedge clk_i);
      #1;
      if (ready_mode == 1) wr_ready_i = 1'($urandom_range(0, 1));
      else if (ready_mode == 0) wr_ready_i = 1'b1;
   end

   initial forever begin
      exp_t e;
      @(negedge clk_i);
      if (rst_i) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!wr_valid_o || wr_port_o !== prev_port) begin
               errors++;
               $display("FAIL hold_stable: valid=%0b addr=%0d required valid=1 addr=%0d with unchanged data",
                        wr_valid_o, wr_port_o.addr, prev_port.addr);
            end
         end
         if (wr_valid_o && wr_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: addr=%0d required no write", wr_port_o.addr);
            end else begin
               e = exp_q.pop_front();
               if (wr_port_o !== e.wp) begin
                  errors++;
                  $display("FAIL write_row: addr=%0d data=%h required addr=%0d data=%h",
                           wr_port_o.addr, wr_port_o.data, e.wp.addr, e.wp.data);
               end else begin
                  $display("write addr=%0d cycle=%0d matched", wr_port_o.addr, cyc);
               end
               if (tput_check && !first_hs) begin
                  checks++;
                  if (cyc - last_hs != BeatsPerRow) begin
                     errors++;
                     $display("FAIL throughput: row spacing %0d required %0d", cyc - last_hs, BeatsPerRow);
                  end
               end
               first_hs = 0;
               last_hs  = cyc;
               if (e.last) done_at = cyc + 1;
            end
         end
         if (done_o || cyc == done_at) begin
            checks++;
            if (!(done_o && cyc == done_at)) begin
               errors++;
               $display("FAIL done_pulse: done=%0b at cycle %0d required done=1 at cycle %0d",
                        done_o, cyc, done_at);
            end
            if (done_o) done_cnt++;
         end
         prev_stall = wr_valid_o && !wr_ready_i;
         prev_port  = wr_port_o;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_bit(input string name, input logic got, input logic req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0b required %0b", name, got, req);
      end
   endtask

   function automatic fifo_data_t beat_data(input int base, input int r, input int k, input int emb);
      fifo_data_t d;
      for (int j = 0; j < N; j++) d[j*WI +: WI] = 8'(base + r*emb + k*N + j);
      return d;
   endfunction

   task automatic expect_row(input int base, input int r, input int emb, input int seq);
      exp_t e;
      e.wp.addr = InputAddrWidth'(r);
      e.wp.data = '0;
      for (int b = 0; b < E; b++) begin
         if (b < emb) e.wp.data[b*WI +: WI] = 8'(base + r*emb + b);
      end
      e.last = (r == seq - 1);
      exp_q.push_back(e);
   endtask

   task automatic send_beat(input fifo_data_t d);
      inp_valid_i = 1'b1;
      inp_data_i  = d;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk_i);
         if (inp_ready_o) begin
            tick();
            inp_valid_i = 1'b0;
            return;
         end
         tick();
      end
      checks++;
      errors++;
      $display("FAIL beat_timeout: inp_ready_o=0 required 1 within 500 cycles");
      inp_valid_i = 1'b0;
   endtask

   task automatic send_row(input int base, input int r, input int emb, input int seq,
                           input int nbeats, input bit gaps);
      for (int k = 0; k < nbeats; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) tick();
         if (k == emb/N - 1) expect_row(base, r, emb, seq);
         send_beat(beat_data(base, r, k, emb));
      end
   endtask

   task automatic start_tile(input int seq, input int emb);
      seq_length_i = seq_length_t'(seq);
      embed_size_i = embed_size_t'(emb);
      start_i      = 1'b1;
      first_hs     = 1;
      if (seq == 0) done_at = cyc + 1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int t = 0; t < 3000; t++) begin
         if (done_cnt >= target) return;
         tick();
      end
      checks++;
      errors++;
      $display("FAIL done_timeout: done count %0d required %0d", done_cnt, target);
   endtask

   task automatic check_idle_outputs(input string tag);
      @(negedge clk_i);
      check_bit({tag, "_inp_ready"}, inp_ready_o, 1'b0);
      check_bit({tag, "_wr_valid"}, wr_valid_o, 1'b0);
      check_bit({tag, "_busy"}, busy_o, 1'b0);
      check_bit({tag, "_done"}, done_o, 1'b0);
      check_bit({tag, "_wr_port_zero"}, |wr_port_o, 1'b0);
   endtask

   initial begin
      rst_i        = 1'b1;
      start_i      = 1'b0;
      inp_valid_i  = 1'b0;
      inp_data_i   = '0;
      wr_ready_i   = 1'b1;
      seq_length_i = '0;
      embed_size_i = '0;
      tick();
      tick();
      check_idle_outputs("reset");
      rst_i = 1'b0;
      tick();

      // Basic tile: four full rows, back-to-back beats, output always ready.
      tput_check = 1;
      start_tile(4, 64);
      check_bit("busy_run", busy_o, 1'b1);
      for (int r = 0; r < 4; r++) send_row(0, r, 64, 4, 4, 0);
      wait_done(1);
      tput_check = 0;
      tick();
      check_bit("busy_after_done", busy_o, 1'b0);

      // Backpressure: row 0 held while row 1 assembles; its last beat stalls.
      ready_mode = 2;
      wr_ready_i = 1'b0;
      start_tile(2, 64);
      send_row(7, 0, 64, 2, 4, 0);
      send_row(7, 1, 64, 2, 3, 0);
      expect_row(7, 1, 64, 2);
      inp_valid_i = 1'b1;
      inp_data_i  = beat_data(7, 1, 3, 64);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         check_bit("stall_last_beat", inp_ready_o, 1'b0);
         tick();
      end
      wr_ready_i = 1'b1;
      send_beat(beat_data(7, 1, 3, 64));
      wait_done(2);
      ready_mode = 0;
      tick();

      // Partial embed: two beats per row, upper half of each row zero.
      start_tile(2, 32);
      for (int r = 0; r < 2; r++) send_row(100, r, 32, 2, 2, 0);
      wait_done(3);
      tick();

      // Zero-length tile: immediate done, no input or output activity.
      start_tile(0, 64);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check_bit("zero_len_inp_ready", inp_ready_o, 1'b0);
         check_bit("zero_len_wr_valid", wr_valid_o, 1'b0);
         tick();
      end
      wait_done(4);
      tick();

      // Full tile with random input gaps and random output ready.
      ready_mode = 1;
      start_tile(64, 64);
      for (int r = 0; r < 64; r++) send_row(3, r, 64, 64, 4, 1);
      wait_done(5);
      ready_mode = 0;
      tick();
      tick();

      // Reset in the middle of row 1, then a one-row tile with fresh data.
      start_tile(2, 64);
      send_row(50, 0, 64, 2, 4, 0);
      send_row(50, 1, 64, 2, 2, 0);
      rst_i = 1'b1;
      tick();
      check_idle_outputs("mid_reset");
      rst_i = 1'b0;
      tick();
      start_tile(1, 64);
      send_row(200, 0, 64, 1, 4, 0);
      wait_done(6);
      tick();
      tick();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_empty: %0d rows outstanding required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ita_input_row_assembler.md
Name: ita_input_row_assembler

Overview:
- Transmitter side of the ITA input-buffer write port.
- Accepts a narrow stream of N-byte beats from the streamer/HWPE side and assembles them into full E-byte token rows.
- Emits each row as a write_port_t (row address plus data) with a valid/ready handshake into the input memory.
- Sequences addresses 0..seq_length-1 for one tile, then signals completion.

Parameters:
- N, 16, bytes per input beat (matches fifo_data_t width N*WI)
- E, 64, bytes per assembled row (write_port_t data width)
- S, 64, maximum rows per tile
- WI, 8, bits per element

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  start pulse: latch config and begin a tile
- seq_length_i  in  seq_length_t  rows in this tile (0..S)
- embed_size_i  in  embed_size_t  valid bytes per row (N..E, multiple of N)
- inp_valid_i  in  1  input beat valid
- inp_ready_o  out  1  input beat ready
- inp_data_i  in  N*WI  input beat; byte j = element j of the beat
- wr_valid_o  out  1  write port valid
- wr_ready_i  in  1  write port ready
- wr_port_o  out  write_port_t  {addr: InputAddrWidth, data: E x WI}
- busy_o  out  1  tile in progress
- done_o  out  1  one-cycle pulse after the last row handshake

Behaviour:
- Reset: one clock (clk_i); reset is synchronous and active-high (rst_i). Reset clears all state. State goes to IDLE; inp_ready_o, wr_valid_o, busy_o and done_o are 0; wr_port_o is all-zero; beat and row counters are 0.
- FSM states:
  - IDLE: on start_i, latch seq_length_i and embed_size_i and compute beats_per_row = embed_size/N. If seq_length_i==0, pulse done_o on the next cycle and stay in IDLE. Otherwise go to RUN.
  - RUN: while in RUN, busy_o=1.
  - DRAIN: entered when the final row has been assembled but not yet handshaken.
  - DRAIN -> IDLE: on the last row's write handshake; done_o=1 in the first IDLE cycle.
- start_i in RUN/DRAIN: ignored.
- Assembly:
  - A beat is accepted when inp_valid_i && inp_ready_o.
  - Beat k of a row is written to row bytes [k*N +: N]; beat_cnt increments per accepted beat.
  - Row bytes at or above embed_size are forced to 0.
- Row completion:
  - The row buffer transfers to the output register in the same cycle as the last-beat acceptance, so the outgoing row includes the incoming beat combinationally.
  - On transfer: wr_valid_o=1 from the next cycle; addr = row_cnt; row_cnt increments; beat_cnt returns to 0.
- Ready rule: inp_ready_o = (state==RUN) && (beat_cnt != beats_per_row-1 || !wr_valid_o || wr_ready_i).
  - Non-last beats are never stalled by the output side.
  - The last beat stalls only while the output register is occupied and not draining.
  - The combinational path wr_ready_i -> inp_ready_o is intentional.
- Output register:
  - wr_valid_o stays high with wr_port_o stable until wr_ready_i.
  - A handshake and a new transfer in the same cycle keep wr_valid_o high with the new row.
- Throughput: with wr_ready_i tied high, one row per beats_per_row cycles, no bubbles.
- Address: 0..seq_length-1 in order; never wraps within a tile; restarts at 0 on each start.
- When the last row (row_cnt==seq_length-1) transfers: stop accepting input (inp_ready_o=0) and go to DRAIN.
- Widths:
  - beat_cnt: idx_width(E/N).
  - row_cnt: idx_width(S+1).
  - Addr output truncates row_cnt to InputAddrWidth; with seq_length<=S the value always fits.
- Reset mid-tile: partial row is discarded; wr_valid_o drops in the same cycle as reset is sampled, i.e. 0 from the next edge.
- Illegal config (embed_size not a multiple of N, 0, or >E; seq_length>S): behaviour undefined; verification asserts against it.

Decomposition:
- ita_package additions:
  - localparam BeatsPerRow = E/N.
  - typedef beat_cnt_t = logic[idx_width(E/N)-1:0].
  - Existing write_port_t, fifo_data_t, seq_length_t and embed_size_t are reused.
- One natural sub-module: ita_row_output_reg, a single-entry valid/ready holding register for write_port_t with simultaneous pop/push support.
- Counters and FSM live in the top module.

Test Plan:
- Basic: N=16, E=64, seq=4, emb=64, wr_ready=1, beats with byte value = global byte index -> 4 writes, addr 0..3; row r byte b = (64r+b) mod 256; one row per 4 cycles; done_o pulses once, one cycle after the addr=3 handshake.
- Backpressure: wr_ready low for 10 cycles during row 0 -> beats 0-2 of row 1 accepted; beat 3 stalls (inp_ready_o=0); wr_port_o stable for all 10 cycles; no data loss or duplication.
- Partial embed: emb=32, seq=2 -> 2 beats per row; data bytes 32..63 are 0; addr 0,1; done_o.
- Full tile: seq=64, random inp_valid/wr_ready -> exactly 64 writes, addr 0..63 in order; scoreboard matches reference packing; no write after done_o.
- Zero length: start with seq=0 -> no wr_valid_o, inp_ready_o stays 0, done_o=1 on the following cycle.
- Reset mid-row: rst_i after 2 beats of row 1 -> all outputs 0; a restart with seq=1 yields addr 0 containing only post-reset data.
